// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent LSB-first as
// start + 8 data + optional parity + 1 or 2 stop bits, timed by a cycle divider.
module uart_tx #(
    parameter int BAUD_DIV  = 2812,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    generate
        if (BAUD_DIV < 2 || BAUD_DIV > 4095 || PARITY < 0 || PARITY > 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
            $error("uart_tx: illegal BAUD_DIV, PARITY or STOP_BITS");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [11:0] BAUD_PRE  = 12'(BAUD_DIV - 2);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    state_t      r_state,    w_state_nxt;
    logic [11:0] r_baud_cnt, w_baud_nxt;
    logic [2:0]  r_bit_cnt,  w_bit_nxt;
    logic [7:0]  r_shift,    w_shift_nxt;
    logic        r_par,      w_par_nxt;
    logic        r_tx,       w_tx_nxt;
    logic        r_ready,    w_ready_nxt;
    logic        r_busy,     w_busy_nxt;
    logic        r_done,     w_done_nxt;
    logic        w_bit_end;

    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    // State and output registers; reset forces the line idle and abandons any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= 12'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par      <= w_par_nxt;
            r_tx       <= w_tx_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state logic; tx is computed from the state being entered so the line is registered.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_tx_nxt    = r_tx;
        w_ready_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        if (r_state != S_IDLE) begin
            w_baud_nxt = w_bit_end ? 12'd0 : r_baud_cnt + 12'd1;
        end else begin
            w_baud_nxt = 12'd0;
        end

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (tx_valid && r_ready) begin
                    w_shift_nxt = tx_data;
                    w_par_nxt   = (PARITY == 2) ? ~(^tx_data) : ^tx_data;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                    w_ready_nxt = 1'b0;
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_tx_nxt    = 1'b0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_nxt = 3'd0;
                        if (PARITY != 0) begin
                            w_state_nxt = S_PARITY;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                        w_tx_nxt  = r_shift[1];
                    end
                end else begin
                    w_tx_nxt = r_shift[0];
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_tx_nxt    = r_par;
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                // done is registered, so it is raised one clock before the last stop clock
                if (r_bit_cnt == STOP_LAST && r_baud_cnt == BAUD_PRE) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_done_nxt = 1'b0;
                end
                if (w_bit_end) begin
                    if (r_bit_cnt == STOP_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = 3'd0;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_bit_nxt = r_bit_cnt;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign tx_ready = r_ready;
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no/even/odd parity and two stop bits.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] d [4];
    logic [3:0] v;
    logic [3:0] rdy;
    logic [3:0] txo;
    logic [3:0] bsy;
    logic [3:0] dn;
    int         n_chk  = 0;
    int         n_pass = 0;

    uart_tx #(.BAUD_DIV(4), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .clk(clk), .rst(rst), .tx_data(d[0]), .tx_valid(v[0]),
        .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .done(dn[0]));
    uart_tx #(.BAUD_DIV(4), .PARITY(1), .STOP_BITS(1)) u_e1 (
        .clk(clk), .rst(rst), .tx_data(d[1]), .tx_valid(v[1]),
        .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .done(dn[1]));
    uart_tx #(.BAUD_DIV(4), .PARITY(2), .STOP_BITS(1)) u_o1 (
        .clk(clk), .rst(rst), .tx_data(d[2]), .tx_valid(v[2]),
        .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .done(dn[2]));
    uart_tx #(.BAUD_DIV(4), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .clk(clk), .rst(rst), .tx_data(d[3]), .tx_valid(v[3]),
        .tx_ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]), .done(dn[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Wait (bounded) for tx_ready, then present a byte; returns in cycle 1 after accept.
    task automatic send(input int i, input logic [7:0] data);
        for (int k = 0; k < 8 && rdy[i] !== 1'b1; k++) @(negedge clk);
        chk($sformatf("ready_before_send_u%0d", i), 32'(rdy[i]), 32'd1);
        d[i] = data;
        v[i] = 1'b1;
        @(negedge clk);
    endtask

    // Check {tx,done,busy,ready} for every clock of a frame; mode 1 abuses the inputs.
    task automatic frame_body(input int i, input logic [7:0] data, input bit has_par,
                              input logic par_bit, input int nstop, input int mode,
                              input string name);
        logic [11:0] fb;
        int nb;
        int tot;
        fb = 12'h000;
        fb[0] = 1'b0;
        for (int k = 0; k < 8; k++) fb[k+1] = data[k];
        nb = 9;
        if (has_par) begin
            fb[nb] = par_bit;
            nb++;
        end
        for (int s = 0; s < nstop; s++) begin
            fb[nb] = 1'b1;
            nb++;
        end
        tot = nb * 4;
        for (int c = 1; c <= tot; c++) begin
            chk($sformatf("%s c%0d {tx,done,busy,ready}", name, c),
                32'({txo[i], dn[i], bsy[i], rdy[i]}),
                32'({fb[(c-1)/4], (c == tot), 1'b1, 1'b0}));
            if (mode == 1) begin
                d[i] = 8'($urandom);
                v[i] = ~v[i];
            end
            if (c < tot) @(negedge clk);
        end
    endtask

    task automatic end_chk(input int i, input string name);
        @(negedge clk);
        chk($sformatf("%s end {tx,ready,busy,done}", name),
            32'({txo[i], rdy[i], bsy[i], dn[i]}), 32'h0000000C);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        v   = 4'b0000;
        for (int i = 0; i < 4; i++) d[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset {tx,ready,busy,done} all", 32'({txo, rdy, bsy, dn}), 32'h0000F000);

        // release: ready rises on the first clock
        rst = 1'b0;
        @(negedge clk);
        chk("release c1 {tx,ready,busy}", 32'({txo[0], rdy[0], bsy[0]}), 32'd6);
        repeat (3) begin
            @(negedge clk);
            chk("idle {tx,ready,busy,done}", 32'({txo[0], rdy[0], bsy[0], dn[0]}), 32'hC);
        end

        // 0x55, no parity, one stop bit
        send(0, 8'h55);
        v[0] = 1'b0;
        frame_body(0, 8'h55, 1'b0, 1'b0, 1, 0, "f55");
        end_chk(0, "f55");

        // parity vectors
        send(1, 8'h01);
        v[1] = 1'b0;
        frame_body(1, 8'h01, 1'b1, 1'b1, 1, 0, "even01");
        end_chk(1, "even01");
        send(2, 8'h01);
        v[2] = 1'b0;
        frame_body(2, 8'h01, 1'b1, 1'b0, 1, 0, "odd01");
        end_chk(2, "odd01");
        send(1, 8'h55);
        v[1] = 1'b0;
        frame_body(1, 8'h55, 1'b1, 1'b0, 1, 0, "even55");
        end_chk(1, "even55");

        // back-to-back with two stop bits, valid held high
        send(3, 8'hA3);
        d[3] = 8'h3C;
        frame_body(3, 8'hA3, 1'b0, 1'b0, 2, 0, "b2bA3");
        @(negedge clk);
        chk("b2b gap {tx,ready,busy,done}", 32'({txo[3], rdy[3], bsy[3], dn[3]}), 32'hC);
        @(negedge clk);
        v[3] = 1'b0;
        frame_body(3, 8'h3C, 1'b0, 1'b0, 2, 0, "b2b3C");
        end_chk(3, "b2b3C");

        // protocol abuse during a 0x0F frame
        send(0, 8'h0F);
        frame_body(0, 8'h0F, 1'b0, 1'b0, 1, 1, "abuse0F");
        @(negedge clk);
        v[0] = 1'b0;
        chk("abuse end {tx,ready,busy,done}", 32'({txo[0], rdy[0], bsy[0], dn[0]}), 32'hC);
        repeat (6) begin
            @(negedge clk);
            chk("abuse no extra frame {tx,busy}", 32'({txo[0], bsy[0]}), 32'd2);
        end

        // reset during data bit 3 of 0xFF
        send(0, 8'hFF);
        v[0] = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            chk($sformatf("preRst c%0d {tx,done}", c), 32'({txo[0], dn[0]}),
                32'({(c > 4), 1'b0}));
            @(negedge clk);
        end
        chk("preRst busy", 32'(bsy[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("async rst {tx,ready,busy,done}", 32'({txo[0], rdy[0], bsy[0], dn[0]}), 32'h8);
        repeat (2) begin
            @(negedge clk);
            chk("in rst {tx,done}", 32'({txo[0], dn[0]}), 32'd2);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("after rst {tx,ready,busy,done}", 32'({txo[0], rdy[0], bsy[0], dn[0]}), 32'hC);
        send(0, 8'h81);
        v[0] = 1'b0;
        frame_body(0, 8'h81, 1'b0, 1'b0, 1, 0, "f81");
        end_chk(0, "f81");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
